phase_seq: RTL and testbench
============================

PHASE_SEQ -- requirements
Module: phase_seq

Interface
REQ-001 Parameter NPH, default 5, number of one-hot phases per instruction; legal range 2..16.
REQ-002 Parameter SYNC, default 2, number of synchroniser flops on start; legal range 2..4.
REQ-003 Parameter CW, default 16, width of the completed-instruction counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  asynchronous run request; a rising edge arms the sequencer.
REQ-007 hlt  input  1  synchronous halt (HLT instruction decoded); returns the sequencer to idle.
REQ-008 stall  input  1  synchronous; holds the current phase.
REQ-009 skip  input  1  synchronous; jumps the current instruction to its last phase.
REQ-010 phase  output  NPH  one-hot current phase, bit 0 = fetch, bit NPH-1 = writeback; all-zero when idle.
REQ-011 running  output  1  high while phase is non-zero.
REQ-012 last  output  1  equals phase[NPH-1].
REQ-013 instr_cnt  output  CW  count of completed instructions.

Function
REQ-014 start SHALL pass through a SYNC-flop synchroniser plus one edge-detect flop; start_edge = sync_out & ~prev.
REQ-015 Priority per edge SHALL be: rst > hlt > start_edge (idle only) > stall > skip > advance.
REQ-016 Idle (phase = 0): start_edge SHALL load phase = 1 (bit 0); all other inputs are ignored except hlt.
REQ-017 Running: start_edge SHALL be ignored; re-arming requires start to fall and rise again.
REQ-018 hlt = 1 SHALL load phase = 0 on the next edge from any state, including when stall or skip is high.
REQ-019 stall = 1 while running SHALL hold phase and instr_cnt unchanged.
REQ-020 advance SHALL rotate phase left by one; bit NPH-1 wraps to bit 0.
REQ-021 skip = 1 while running and not in the last phase SHALL load phase = bit NPH-1.
REQ-022 skip = 1 in the last phase SHALL behave as a normal advance to bit 0.
REQ-023 instr_cnt SHALL increment by 1 on every transition from bit NPH-1 to bit 0, and wrap modulo 2^CW without saturation.
REQ-024 A halt taken in the last phase SHALL NOT increment instr_cnt.
REQ-025 Latency: when start is first sampled high at edge E while idle, phase SHALL become 1 at edge E+SYNC+... i.e. phase[0] goes high on edge E+SYNC, with E counted as the first sampling edge (SYNC=2: third edge).
REQ-026 phase SHALL never hold more than one set bit; any other value is a design error.
REQ-027 Outputs SHALL be registered or direct decodes of registered state; there is no combinational path from any input to any output.

Reset
REQ-028 On rst = 1 the block SHALL clear phase, instr_cnt, the synchroniser flops and the edge flop asynchronously, so that running = 0 and last = 0.
REQ-029 rst asserted mid-instruction SHALL abort the instruction with no increment of instr_cnt.
REQ-030 If start is held high across reset release, a start_edge SHALL occur SYNC edges after release and the sequencer SHALL start.

Verification
REQ-031 NPH=5, SYNC=2: rst, then start held high -> phase 00001 on edge 3, then 00010, 00100, 01000, 10000, then 00001; instr_cnt = 1.
REQ-032 Running in phase 00100, stall held for 3 cycles -> phase stays 00100 for 3 cycles, then 01000.
REQ-033 skip in phase 00010 -> next 10000; skip in 10000 -> next 00001 and instr_cnt += 1.
REQ-034 hlt together with stall in phase 10000 -> phase 00000 and instr_cnt unchanged; start re-pulsed -> restart at 00001.
REQ-035 CW=4 with 16 completed instructions -> instr_cnt wraps from 15 to 0.
REQ-036 rst pulsed asynchronously mid-cycle in phase 01000 -> phase 00000 immediately, before the next clock edge.

Source files
------------

// File: rtl/phase_seq.sv
// phase_seq: one-hot instruction phase sequencer.
//
// An asynchronous start request is synchronised and edge-detected. A rising
// edge seen while idle launches the sequencer into the fetch phase (bit 0).
// The one-hot phase then rotates left once per clock. Writeback (bit NPH-1)
// wraps back to fetch, and every such wrap counts one completed instruction.
// hlt returns the sequencer to idle from any state. stall freezes the phase.
// skip jumps straight to writeback.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      asynchronous run request (a rising edge arms the sequencer)
//   hlt        synchronous halt, highest priority after rst
//   stall      synchronous hold of the current phase
//   skip       synchronous jump to the last phase
//   phase      one-hot current phase, all-zero when idle
//   running    high while phase is non-zero
//   last       high in the writeback phase
//   instr_cnt  completed-instruction count, wraps modulo 2^CW
module phase_seq #(
    parameter int NPH  = 5,
    parameter int SYNC = 2,
    parameter int CW   = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           hlt,
    input  logic           stall,
    input  logic           skip,
    output logic [NPH-1:0] phase,
    output logic           running,
    output logic           last,
    output logic [CW-1:0]  instr_cnt
);

    localparam logic [NPH-1:0] PH_FIRST = {{(NPH-1){1'b0}}, 1'b1};
    localparam logic [NPH-1:0] PH_LAST  = {1'b1, {(NPH-1){1'b0}}};

    logic [SYNC-1:0] sync_q;
    logic            edge_q;
    logic [NPH-1:0]  phase_q, phase_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            start_edge;

    // The edge flop always follows the synchroniser output, even while
    // running. A start held high therefore cannot re-arm the sequencer after
    // a halt; start must fall and rise again.
    assign start_edge = sync_q[SYNC-1] & ~edge_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            edge_q  <= 1'b0;
            phase_q <= '0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC-2:0], start};
            edge_q  <= sync_q[SYNC-1];
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    // Priority: hlt > start_edge (idle only) > stall > skip > advance.
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (hlt) begin
            // A halt taken in writeback is not a completion, so there is no count.
            phase_d = '0;
        end else if (phase_q == '0) begin
            if (start_edge) begin
                phase_d = PH_FIRST;
            end
        end else if (stall) begin
            phase_d = phase_q;
        end else if (skip && !phase_q[NPH-1]) begin
            phase_d = PH_LAST;
        end else begin
            // A normal advance. skip in writeback also lands here.
            phase_d = {phase_q[NPH-2:0], phase_q[NPH-1]};
            if (phase_q[NPH-1]) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign phase     = phase_q;
    assign running   = |phase_q;
    assign last      = phase_q[NPH-1];
    assign instr_cnt = cnt_q;

    onehot_phase: assert property (@(posedge clk) disable iff (rst) $onehot0(phase_q));

endmodule

// File: tb/tb_phase_seq.sv
module tb_phase_seq;
  localparam int NPH  = 5;
  localparam int SYNC = 2;
  localparam int CW   = 4;
  localparam int W    = NPH + 2 + CW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic hlt = 1'b0;
  logic stall = 1'b0;
  logic skip = 1'b0;
  logic [NPH-1:0] phase;
  logic running;
  logic last;
  logic [CW-1:0] instr_cnt;

  phase_seq #(.NPH(NPH), .SYNC(SYNC), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .hlt(hlt), .stall(stall), .skip(skip),
    .phase(phase), .running(running), .last(last), .instr_cnt(instr_cnt)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference model: ph = 0 idle, 1..NPH = phase number; hist = start samples
  int   ph = 0;
  int   cnt = 0;
  logic hist[$];
  logic start_lvl = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (phase,running,last,instr_cnt) at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_out();
    logic [NPH-1:0] pv;
    logic [CW-1:0] c;
    pv = '0;
    if (ph != 0) pv[ph-1] = 1'b1;
    c = CW'(cnt);
    return {pv, logic'(ph != 0), logic'(ph == NPH), c};
  endfunction

  function automatic void model_reset();
    ph = 0;
    cnt = 0;
    hist = {};
    for (int i = 0; i < SYNC + 1; i++) hist.push_back(1'b0);
  endfunction

  // model of one rising edge given the inputs held across it
  function automatic void model_edge(input logic st, input logic h, input logic sl,
                                     input logic sk, input logic r);
    logic se;
    if (r) begin
      model_reset();
      return;
    end
    // start seen at the edge SYNC edges ago is high and the one before it was low
    se = hist[hist.size() - SYNC] & ~hist[hist.size() - SYNC - 1];
    hist.push_back(st);
    void'(hist.pop_front());
    if (h) ph = 0;
    else if (ph == 0) begin
      if (se) ph = 1;
    end
    else if (sl) ph = ph;
    else if (sk && ph != NPH) ph = NPH;
    else if (ph == NPH) begin
      ph = 1;
      cnt = (cnt + 1) % (1 << CW);
    end
    else ph = ph + 1;
  endfunction

  // driver: inputs change on the falling edge, expectation queued for next rise
  task automatic step(input logic st, input logic h, input logic sl, input logic sk, input logic r);
    @(negedge clk);
    start = st;
    hlt = h;
    stall = sl;
    skip = sk;
    rst = r;
    model_edge(st, h, sl, sk, r);
    exp_q.push_back(model_out());
  endtask

  task automatic idle_step();
    step(start_lvl, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_to(input int target);
    int n;
    n = 0;
    while (ph != target && n < 4 * NPH) begin
      idle_step();
      n++;
    end
    checks++;
    if (ph != target) begin
      errors++;
      $display("FAIL run_to: model phase %0d expected %0d", ph, target);
    end
  endtask

  // reset pulse well away from both clock edges; clears state immediately
  task automatic async_reset_pulse();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_reset", {phase, running, last, instr_cnt}, model_out());
    rst = 1'b0;
  endtask

  // monitor: pops and compares one expectation per rising edge
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", {phase, running, last, instr_cnt}, e);
      end
    end
  end

  initial begin
    model_reset();
    #1;
    rst = 1'b1;
    #1;
    check("reset_state", {phase, running, last, instr_cnt}, model_out());
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // release, start held high: fetch appears on third edge, one full instruction
    start_lvl = 1'b1;
    repeat (9) idle_step();

    // stall three cycles in phase 3
    run_to(3);
    repeat (3) step(start_lvl, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_step();

    // skip from phase 2 to writeback, then skip in writeback completes
    run_to(2);
    step(start_lvl, 1'b0, 1'b0, 1'b1, 1'b0);
    step(start_lvl, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_step();

    // halt with stall in writeback: idle, no count; held start does not re-arm
    run_to(NPH);
    step(start_lvl, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) idle_step();
    start_lvl = 1'b0;
    repeat (3) idle_step();
    start_lvl = 1'b1;
    repeat (5) idle_step();

    // asynchronous reset mid-instruction with start held high: restarts
    run_to(4);
    async_reset_pulse();
    repeat (6) idle_step();

    // long free run so the 4-bit counter wraps
    repeat (18 * NPH) idle_step();

    // randomized stimulus
    for (int i = 0; i < 800; i++) begin
      logic h, sl, sk, r;
      if ($urandom_range(0, 9) == 0) start_lvl = ~start_lvl;
      h  = ($urandom_range(0, 39) == 0);
      sl = ($urandom_range(0, 6) == 0);
      sk = ($urandom_range(0, 9) == 0);
      r  = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 199) == 0) async_reset_pulse();
      step(start_lvl, h, sl, sk, r);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // drain scoreboard within a bounded number of edges
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
